// File: rtl/mempool_link_arbiter_if.sv
// Handshake bundle for mempool_link_arbiter: two request sources, the shared link,
// and the per-source response return path.
interface mempool_link_arbiter_if #(
  parameter int unsigned ReqWidth  = 64,
  parameter int unsigned RespWidth = 40
);
  logic [1:0][ReqWidth-1:0]  req_i;
  logic [1:0]                req_valid_i;
  logic [1:0]                req_ready_o;
  logic [ReqWidth-1:0]       link_req_o;
  logic                      link_valid_o;
  logic                      link_ready_i;
  logic [RespWidth-1:0]      link_resp_i;
  logic                      link_resp_valid_i;
  logic                      link_resp_ready_o;
  logic [1:0][RespWidth-1:0] resp_o;
  logic [1:0]                resp_valid_o;
  logic [1:0]                resp_ready_i;
  logic                      err_o;

  modport slave (
    input  req_i, req_valid_i, link_ready_i, link_resp_i, link_resp_valid_i, resp_ready_i,
    output req_ready_o, link_req_o, link_valid_o, link_resp_ready_o, resp_o, resp_valid_o, err_o
  );

  modport master (
    output req_i, req_valid_i, link_ready_i, link_resp_i, link_resp_valid_i, resp_ready_i,
    input  req_ready_o, link_req_o, link_valid_o, link_resp_ready_o, resp_o, resp_valid_o, err_o
  );
endinterface

// File: rtl/mempool_link_arbiter.sv
// Two-source round-robin arbiter onto one registered TCDM link, with a route FIFO
// steering in-order responses back. Optional counters: MEMPOOL_LINK_ARB_STATS_EN.
module mempool_link_arbiter #(
  parameter int unsigned ReqWidth       = 64,
  parameter int unsigned RespWidth      = 40,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  mempool_link_arbiter_if.slave bus
`ifdef MEMPOOL_LINK_ARB_STATS_EN
  ,
  output logic [1:0][31:0] grant_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);
  localparam int unsigned AW = $clog2(MaxOutstanding);

  logic                      link_valid_q;
  logic [ReqWidth-1:0]       link_req_q;
  logic                      rr_q;
  logic                      err_q;
  logic [MaxOutstanding-1:0] route_q;
  logic [AW-1:0]             wptr_q;
  logic [AW-1:0]             rptr_q;
  logic [AW:0]               count_q;

  logic       fifo_full, fifo_empty, head;
  logic       slot_free, can_grant, any_valid, winner, grant;
  logic       pop, drop;
  logic [1:0] req_ready, resp_valid;
  logic       link_resp_ready;

  assign fifo_full  = (count_q == (AW+1)'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);
  assign head       = route_q[rptr_q];

  always_comb begin
    slot_free = !link_valid_q | bus.link_ready_i;
    // Readies are held low while reset is asserted so nothing is accepted then.
    can_grant = slot_free & !fifo_full & !rst_i;
    any_valid = |bus.req_valid_i;
    winner    = (&bus.req_valid_i) ? rr_q : bus.req_valid_i[1];
    grant     = can_grant & any_valid;
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;

    resp_valid      = '0;
    link_resp_ready = 1'b1;
    if (!fifo_empty) begin
      resp_valid[head] = bus.link_resp_valid_i;
      link_resp_ready  = bus.resp_ready_i[head];
    end
    pop  = !fifo_empty & bus.link_resp_valid_i & bus.resp_ready_i[head];
    drop = fifo_empty & bus.link_resp_valid_i;
  end

  // Stage p0 -> p1: registered link output, route FIFO bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      link_valid_q <= 1'b0;
      link_req_q   <= '0;
      rr_q         <= 1'b0;
      err_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      if (grant) begin
        link_valid_q <= 1'b1;
        link_req_q   <= bus.req_i[winner];
        rr_q         <= ~rr_q;
        wptr_q       <= wptr_q + 1'b1;
      end else if (bus.link_ready_i) begin
        link_valid_q <= 1'b0;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) err_q <= 1'b1;
    end
  end

  // Route storage is data only; occupancy is tracked by the pointers above.
  always_ff @(posedge clk_i) begin
    if (grant) route_q[wptr_q] <= winner;
  end

  assign bus.req_ready_o       = req_ready;
  assign bus.link_valid_o      = link_valid_q;
  assign bus.link_req_o        = link_req_q;
  assign bus.link_resp_ready_o = link_resp_ready;
  assign bus.resp_o            = {bus.link_resp_i, bus.link_resp_i};
  assign bus.resp_valid_o      = resp_valid;
  assign bus.err_o             = err_q;

`ifdef MEMPOOL_LINK_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [1:0][31:0] grant_cnt_q;
  logic [31:0]      stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant) grant_cnt_q[winner] <= sat_inc(grant_cnt_q[winner]);
      if (any_valid && !can_grant) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mempool_link_arbiter.sv
// Directed bench for mempool_link_arbiter: arbitration order, backpressure,
// route FIFO fill/drain, response steering and the sticky error flag.
module tb_mempool_link_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  mempool_link_arbiter_if #(.ReqWidth(64), .RespWidth(40)) bus ();

`ifdef MEMPOOL_LINK_ARB_STATS_EN
  logic [1:0][31:0] grant_cnt;
  logic [31:0]      stall_cnt;
`endif

  mempool_link_arbiter #(
    .ReqWidth(64), .RespWidth(40), .MaxOutstanding(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef MEMPOOL_LINK_ARB_STATS_EN
    ,
    .grant_cnt_o (grant_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.req_valid_i = 2'b00;
    bus.link_ready_i = 1'b0;
    bus.link_resp_i = '0;
    bus.link_resp_valid_i = 1'b0;
    bus.resp_ready_i = 2'b00;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.req_valid_i = 2'b11;
    bus.link_ready_i = 1'b1;
    bus.link_resp_i = '0;
    bus.link_resp_valid_i = 1'b1;
    bus.resp_ready_i = 2'b11;
    cyc();
    cyc();
    #1;
    total++; if (bus.link_valid_o !== 1'b0) $display("FAIL reset_link_valid got %b exp 0", bus.link_valid_o); else passed++;
    total++; if (bus.link_req_o !== 64'h0) $display("FAIL reset_link_req got %h exp 0", bus.link_req_o); else passed++;
    total++; if (bus.req_ready_o !== 2'b00) $display("FAIL reset_req_ready got %b exp 00", bus.req_ready_o); else passed++;
    total++; if (bus.resp_valid_o !== 2'b00) $display("FAIL reset_resp_valid got %b exp 00", bus.resp_valid_o); else passed++;
    total++; if (bus.err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [63:0] prev;
    logic [1:0]  exp_rdy;
    do_reset();
    prev = '0;
    bus.link_ready_i = 1'b1;
    bus.req_valid_i = 2'b11;
    for (int i = 0; i < 6; i++) begin
      bus.req_i[0] = 64'h100 + 64'(i);
      bus.req_i[1] = 64'h200 + 64'(i);
      #1;
      exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
      total++; if (bus.req_ready_o !== exp_rdy) $display("FAIL rr_ready[%0d] got %b exp %b", i, bus.req_ready_o, exp_rdy); else passed++;
      if (i == 0) begin
        total++; if (bus.link_valid_o !== 1'b0) $display("FAIL rr_latency got %b exp 0", bus.link_valid_o); else passed++;
      end else begin
        total++; if (bus.link_valid_o !== 1'b1) $display("FAIL rr_link_valid[%0d] got %b exp 1", i, bus.link_valid_o); else passed++;
        total++; if (bus.link_req_o !== prev) $display("FAIL rr_link_req[%0d] got %h exp %h", i, bus.link_req_o, prev); else passed++;
      end
      prev = (i % 2 == 1) ? 64'h200 + 64'(i) : 64'h100 + 64'(i);
      cyc();
    end
  endtask

  task automatic test_single_src();
    do_reset();
    bus.link_ready_i = 1'b1;
    bus.req_valid_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      bus.req_i[1] = 64'h300 + 64'(i);
      #1;
      total++; if (bus.req_ready_o !== 2'b10) $display("FAIL single_ready[%0d] got %b exp 10", i, bus.req_ready_o); else passed++;
      cyc();
    end
    bus.req_valid_i = 2'b11;
    bus.req_i[0] = 64'h400;
    bus.req_i[1] = 64'h4ff;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) $display("FAIL single_ptr_back got %b exp 01", bus.req_ready_o); else passed++;
    total++; if (bus.link_req_o !== 64'h303) $display("FAIL single_last_req got %h exp 303", bus.link_req_o); else passed++;
    cyc();
    total++; if (bus.link_req_o !== 64'h400) $display("FAIL single_both_req got %h exp 400", bus.link_req_o); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.link_ready_i = 1'b1;
    bus.req_valid_i = 2'b01;
    bus.req_i[0] = 64'h500;
    cyc();
    bus.link_ready_i = 1'b0;
    bus.req_valid_i = 2'b11;
    bus.req_i[0] = 64'h501;
    bus.req_i[1] = 64'h601;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.req_ready_o !== 2'b00) $display("FAIL bp_ready[%0d] got %b exp 00", i, bus.req_ready_o); else passed++;
      total++; if (bus.link_req_o !== 64'h500) $display("FAIL bp_hold_req[%0d] got %h exp 500", i, bus.link_req_o); else passed++;
      total++; if (bus.link_valid_o !== 1'b1) $display("FAIL bp_hold_valid[%0d] got %b exp 1", i, bus.link_valid_o); else passed++;
      cyc();
    end
    bus.link_ready_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== 2'b10) $display("FAIL bp_resume_ready got %b exp 10", bus.req_ready_o); else passed++;
    cyc();
    total++; if (bus.link_req_o !== 64'h601) $display("FAIL bp_resume_req got %h exp 601", bus.link_req_o); else passed++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    bus.link_ready_i = 1'b1;
    bus.req_valid_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      bus.req_i[0] = 64'h700 + 64'(i);
      #1;
      total++; if (bus.req_ready_o !== 2'b01) $display("FAIL fill_ready[%0d] got %b exp 01", i, bus.req_ready_o); else passed++;
      cyc();
    end
    #1;
    total++; if (bus.req_ready_o !== 2'b00) $display("FAIL full_ready got %b exp 00", bus.req_ready_o); else passed++;
    total++; if (bus.link_req_o !== 64'h707) $display("FAIL full_last_req got %h exp 707", bus.link_req_o); else passed++;
    bus.link_resp_valid_i = 1'b1;
    bus.link_resp_i = 40'habc;
    bus.resp_ready_i = 2'b01;
    #1;
    total++; if (bus.resp_valid_o !== 2'b01) $display("FAIL full_resp_valid got %b exp 01", bus.resp_valid_o); else passed++;
    total++; if (bus.link_resp_ready_o !== 1'b1) $display("FAIL full_resp_ready got %b exp 1", bus.link_resp_ready_o); else passed++;
    total++; if (bus.req_ready_o !== 2'b00) $display("FAIL full_pop_ready got %b exp 00", bus.req_ready_o); else passed++;
    total++; if (bus.resp_o[0] !== 40'habc) $display("FAIL full_resp_data got %h exp abc", bus.resp_o[0]); else passed++;
    cyc();
    bus.link_resp_valid_i = 1'b0;
    bus.resp_ready_i = 2'b00;
    #1;
    total++; if (bus.link_valid_o !== 1'b0) $display("FAIL full_link_drain got %b exp 0", bus.link_valid_o); else passed++;
    total++; if (bus.req_ready_o !== 2'b01) $display("FAIL full_resume_ready got %b exp 01", bus.req_ready_o); else passed++;
    cyc();
  endtask

  task automatic test_resp_order();
    do_reset();
    bus.link_ready_i = 1'b1;
    bus.req_valid_i = 2'b01; bus.req_i[0] = 64'ha0;
    cyc();
    bus.req_valid_i = 2'b10; bus.req_i[1] = 64'hb0;
    cyc();
    bus.req_valid_i = 2'b01; bus.req_i[0] = 64'ha1;
    cyc();
    bus.req_valid_i = 2'b00;
    bus.link_resp_valid_i = 1'b1;
    bus.link_resp_i = 40'h111;
    bus.resp_ready_i = 2'b00;
    #1;
    total++; if (bus.resp_valid_o !== 2'b01) $display("FAIL order_valid0 got %b exp 01", bus.resp_valid_o); else passed++;
    total++; if (bus.link_resp_ready_o !== 1'b0) $display("FAIL order_stall0 got %b exp 0", bus.link_resp_ready_o); else passed++;
    bus.resp_ready_i = 2'b01;
    #1;
    total++; if (bus.link_resp_ready_o !== 1'b1) $display("FAIL order_ready0 got %b exp 1", bus.link_resp_ready_o); else passed++;
    cyc();
    bus.link_resp_i = 40'h222;
    bus.resp_ready_i = 2'b01;
    #1;
    total++; if (bus.resp_valid_o !== 2'b10) $display("FAIL order_valid1 got %b exp 10", bus.resp_valid_o); else passed++;
    total++; if (bus.link_resp_ready_o !== 1'b0) $display("FAIL order_stall1 got %b exp 0", bus.link_resp_ready_o); else passed++;
    bus.resp_ready_i = 2'b10;
    #1;
    total++; if (bus.link_resp_ready_o !== 1'b1) $display("FAIL order_ready1 got %b exp 1", bus.link_resp_ready_o); else passed++;
    total++; if (bus.resp_o[1] !== 40'h222) $display("FAIL order_data1 got %h exp 222", bus.resp_o[1]); else passed++;
    cyc();
    bus.link_resp_i = 40'h333;
    bus.resp_ready_i = 2'b01;
    #1;
    total++; if (bus.resp_valid_o !== 2'b01) $display("FAIL order_valid2 got %b exp 01", bus.resp_valid_o); else passed++;
    cyc();
    bus.link_resp_valid_i = 1'b0;
    bus.resp_ready_i = 2'b00;
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) $display("FAIL order_drained got %b exp 00", bus.resp_valid_o); else passed++;
    total++; if (bus.err_o !== 1'b0) $display("FAIL order_err got %b exp 0", bus.err_o); else passed++;
  endtask

  task automatic test_err_mid_reset();
    do_reset();
    bus.link_ready_i = 1'b0;
    bus.req_valid_i = 2'b01;
    bus.req_i[0] = 64'h800;
    cyc();
    bus.req_valid_i = 2'b00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    total++; if (bus.link_valid_o !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", bus.link_valid_o); else passed++;
    total++; if (bus.link_req_o !== 64'h0) $display("FAIL mid_rst_req got %h exp 0", bus.link_req_o); else passed++;
    bus.link_resp_valid_i = 1'b1;
    bus.link_resp_i = 40'h999;
    bus.resp_ready_i = 2'b11;
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) $display("FAIL err_resp_valid got %b exp 00", bus.resp_valid_o); else passed++;
    total++; if (bus.link_resp_ready_o !== 1'b1) $display("FAIL err_drop_ready got %b exp 1", bus.link_resp_ready_o); else passed++;
    total++; if (bus.err_o !== 1'b0) $display("FAIL err_early got %b exp 0", bus.err_o); else passed++;
    cyc();
    bus.link_resp_valid_i = 1'b0;
    #1;
    total++; if (bus.err_o !== 1'b1) $display("FAIL err_set got %b exp 1", bus.err_o); else passed++;
    cyc();
    cyc();
    total++; if (bus.err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", bus.err_o); else passed++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    total++; if (bus.err_o !== 1'b0) $display("FAIL err_cleared got %b exp 0", bus.err_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_src();
    test_backpressure();
    test_fifo_full();
    test_resp_order();
    test_err_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
